// File: rtl/irrigation_pkg.sv
// Shared types and constants for the irrigation timer and its synchronizer.
package irrigation_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } timer_state_t;

   localparam int SYNC_STAGES = 2;

endpackage : irrigation_pkg

// File: rtl/edge_sync.sv
// Brings an asynchronous level into the clk domain and flags each rising edge
// with a single-cycle pulse. Reusable for divided clocks and slow sensor inputs.
module edge_sync
   import irrigation_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // NOTE: flops use non-blocking assignments so every stage samples the
   // pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : edge_sync

// File: rtl/irrigation_timer.sv
// Loadable countdown of slow-clock ticks driving the valve enable, with a
// one-cycle completion pulse. Outputs are decoded purely from registers.
module irrigation_timer
   import irrigation_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         slow_clk_in,
   input  logic         start,
   input  logic [W-1:0] duration,
   input  logic         abort,
   output logic         busy,
   output logic         valve_on,
   output logic         done,
   output logic [W-1:0] remaining
);

   timer_state_t state_q, state_d;
   logic [W-1:0] remaining_q, remaining_d;
   logic         tick;

   edge_sync u_edge_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (slow_clk_in),
      .rise     (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
      end
   end

   // NOTE: every output of this block is given a default before the case so
   // that no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (duration != '0) begin
                  remaining_d = duration;
                  state_d     = RUN;
               end else begin
                  remaining_d = '0;
                  state_d     = DONE;
               end
            end
         end
         RUN: begin
            // abort wins over a coincident tick: no decrement, no done pulse
            if (abort) begin
               remaining_d = '0;
               state_d     = IDLE;
            end else if (tick) begin
               remaining_d = remaining_q - W'(1);
               if (remaining_q == W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d     = IDLE;
            remaining_d = '0;
         end
      endcase
   end

   assign busy      = (state_q == RUN);
   assign valve_on  = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign remaining = remaining_q;

endmodule : irrigation_timer

// File: tb/tb_irrigation_timer.sv
// Directed bench for irrigation_timer: a delay-line/countdown model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_irrigation_timer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         slow_clk_in = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] duration = '0;
   logic         abort = 1'b0;
   logic         busy, valve_on, done;
   logic [W-1:0] remaining;

   int errors = 0;
   int checks = 0;

   irrigation_timer #(.W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .slow_clk_in (slow_clk_in),
      .start       (start),
      .duration    (duration),
      .abort       (abort),
      .busy        (busy),
      .valve_on    (valve_on),
      .done        (done),
      .remaining   (remaining)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Slow clock: toggles every 10 clk cycles (period 20) while enabled.
   logic slow_en = 1'b0;
   int   slow_cnt = 0;
   int   n_rise = 0;
   initial forever begin
      @(posedge clk);
      #1;
      if (slow_en) begin
         slow_cnt++;
         if (slow_cnt == 10) begin
            slow_cnt = 0;
            slow_clk_in = ~slow_clk_in;
            if (slow_clk_in) n_rise++;
         end
      end
   end

   // Model: the slow input seen through a delay line of edge samples; a tick
   // is "high two edges ago, low three edges ago". The countdown is expressed
   // as a busy flag, ticks left, and a pending completion pulse.
   logic h0, h1, h2;
   logic m_busy, m_done, m_tick_last;
   int   m_left;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         h0 = 0; h1 = 0; h2 = 0;
         m_busy = 0; m_done = 0; m_left = 0; m_tick_last = 0;
      end else begin
         logic t, was_done;
         t = h1 & ~h2;
         m_tick_last = t;
         was_done = m_done;
         m_done = 0;
         if (!m_busy && !was_done) begin
            if (start) begin
               if (duration == 0) m_done = 1;
               else begin
                  m_busy = 1;
                  m_left = int'(duration);
               end
            end
         end else if (m_busy) begin
            if (abort) begin
               m_busy = 0;
               m_left = 0;
            end else if (t) begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  m_busy = 0;
                  m_done = 1;
               end
            end
         end
         h2 = h1; h1 = h0; h0 = slow_clk_in;
      end
   end

   int done_cnt = 0;
   always @(negedge clk) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("valve_on", 32'(valve_on), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("remaining", 32'(remaining), 32'(m_left));
      if (done) done_cnt++;
   end

   task automatic start_timer(input logic [W-1:0] d);
      @(posedge clk); #1;
      start = 1'b1;
      duration = d;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int bound);
      int i;
      for (i = 0; i < bound; i++) begin
         @(posedge clk); #1;
         if (done) break;
      end
      if (i == bound) check({name, "_timeout"}, 32'(i), 32'(bound - 1));
   endtask

   task automatic wait_rise(input string name);
      int r = n_rise;
      int i;
      for (i = 0; i < 40; i++) begin
         @(posedge clk); #2;
         if (n_rise != r) break;
      end
      if (i == 40) check({name, "_rise_timeout"}, 32'(i), 32'(0));
   endtask

   task automatic wait_remaining(input string name, input int value);
      int i;
      for (i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (int'(remaining) == value) break;
      end
      if (i == 400) check({name, "_timeout"}, 32'(remaining), 32'(value));
   endtask

   initial begin
      int d0, lat;
      logic [W-1:0] r0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_remaining", 32'(remaining), 32'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // Normal run of 3 ticks with edge-to-decrement latency measured.
      start_timer(8'd3);
      check("run3_busy", 32'(busy), 32'd1);
      check("run3_valve", 32'(valve_on), 32'd1);
      check("run3_load", 32'(remaining), 32'd3);
      slow_en = 1'b1;
      d0 = done_cnt;
      for (int k = 0; k < 3; k++) begin
         wait_rise("run3");
         r0 = remaining;
         lat = 0;
         for (int j = 1; j <= 5; j++) begin
            @(posedge clk); #1;
            if (remaining != r0) begin
               lat = j;
               break;
            end
         end
         check("run3_latency", 32'(lat), 32'd3);
         check("run3_value", 32'(remaining), 32'(2 - k));
      end
      check("run3_done_at_end", 32'(done), 32'd1);
      check("run3_busy_at_end", 32'(busy), 32'd0);
      @(posedge clk); #1;
      check("run3_done_pulse_width", 32'(done), 32'd0);
      check("run3_done_count", 32'(done_cnt - d0), 32'd1);

      // Zero duration: done the cycle after accept, valve never enabled.
      slow_en = 1'b0;
      start_timer(8'd0);
      check("zero_done", 32'(done), 32'd1);
      check("zero_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      check("zero_done_low", 32'(done), 32'd0);

      // Ticks in IDLE are discarded.
      slow_en = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      check("idle_ticks_remaining", 32'(remaining), 32'd0);

      // Abort coincident with the 5th tick of a 10-tick run.
      d0 = done_cnt;
      start_timer(8'd10);
      wait_remaining("abort_pre", 6);
      wait_rise("abort");
      @(posedge clk);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_on_tick", 32'(m_tick_last), 32'd1);
      check("abort_remaining", 32'(remaining), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      repeat (40) @(posedge clk);
      #1;
      check("abort_no_done", 32'(done_cnt - d0), 32'd0);

      // start with duration=200 during RUN is ignored.
      start_timer(8'd2);
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      duration = 8'd200;
      @(posedge clk); #1;
      start = 1'b0;
      check("ignored_start", 32'(remaining <= 8'd2), 32'd1);
      wait_done("ignored", 200);
      check("ignored_done_rem", 32'(remaining), 32'd0);

      // Reset while running with 5 left: outputs clear within the cycle.
      repeat (3) @(posedge clk);
      start_timer(8'd8);
      wait_remaining("rst_pre", 5);
      #2;
      rst = 1'b1;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valve", 32'(valve_on), 32'd0);
      check("rst_remaining", 32'(remaining), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      d0 = done_cnt;
      repeat (50) @(posedge clk);
      #1;
      check("rst_no_done", 32'(done_cnt - d0), 32'd0);

      // Maximum duration, then re-start in the first IDLE cycle.
      d0 = n_rise;
      start_timer(8'd255);
      wait_done("max", 6000);
      check("max_done", 32'(done), 32'd1);
      check("max_rises", 32'((n_rise - d0) >= 255 && (n_rise - d0) <= 256), 32'd1);
      @(posedge clk); #1;
      start = 1'b1;
      duration = 8'd2;
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_busy", 32'(busy), 32'd1);
      check("b2b_load", 32'(remaining), 32'd2);
      wait_done("b2b", 200);
      check("b2b_done", 32'(done), 32'd1);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_irrigation_timer
